// File: rtl/phi_position_pkg.sv
// Shared definitions for the phi^n position scan scheduler.
//   - position class codes
//   - Q14 fixed-point constants used by the classifier lane
//   - danger window bounds on the raw exponent
//   - scheduler FSM state encoding
package phi_position_pkg;

    localparam logic [1:0] CLASS_INTEGER_BOUNDARY = 2'b00;
    localparam logic [1:0] CLASS_HALF             = 2'b01;
    localparam logic [1:0] CLASS_QUARTER          = 2'b10;
    localparam logic [1:0] CLASS_NEAR_CATASTROPHE = 2'b11;

    localparam int Q14_0P125 = 2048;
    localparam int Q14_0P25  = 4096;
    localparam int Q14_0P5   = 8192;
    localparam int Q14_0P75  = 12288;
    localparam int Q14_1P0   = 16384;

    // Raw exponent window (about 1.35 .. 1.55) that is always near-catastrophe.
    localparam int N_DANGER_LOW  = 22118;
    localparam int N_DANGER_HIGH = 25395;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/phi_position_classifier_lane.sv
// Combinational phi^n position classifier for one exponent.
// Ports:
//   n_in       in  WIDTH  signed Q14 exponent
//   pos_class  out 2      00 integer, 01 half, 10 quarter, 11 near-catastrophe
//   stability  out WIDTH  Q14 stability score
module phi_position_classifier_lane #(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic [WIDTH-1:0] n_in,
    output logic [1:0]       pos_class,
    output logic [WIDTH-1:0] stability
);
    import phi_position_pkg::*;

    localparam logic signed [WIDTH-1:0] DANGER_LO = WIDTH'(N_DANGER_LOW);
    localparam logic signed [WIDTH-1:0] DANGER_HI = WIDTH'(N_DANGER_HIGH);
    localparam logic [WIDTH-1:0] C_0P125 = WIDTH'(Q14_0P125);
    localparam logic [WIDTH-1:0] C_0P25  = WIDTH'(Q14_0P25);
    localparam logic [WIDTH-1:0] C_0P5   = WIDTH'(Q14_0P5);
    localparam logic [WIDTH-1:0] C_0P75  = WIDTH'(Q14_0P75);
    localparam logic [WIDTH-1:0] C_1P0   = WIDTH'(Q14_1P0);
    localparam logic [WIDTH-1:0] C_0P875 = WIDTH'(Q14_1P0 - Q14_0P125);

    logic signed [WIDTH-1:0] n_s;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] d_half;
    logic [WIDTH-1:0] d_q1;
    logic [WIDTH-1:0] d_q3;

    always_comb begin
        n_s    = n_in;
        f      = {{(WIDTH-FRAC){1'b0}}, n_in[FRAC-1:0]};
        d_half = (f >= C_0P5)  ? f - C_0P5  : C_0P5 - f;
        d_q1   = (f >= C_0P25) ? f - C_0P25 : C_0P25 - f;
        d_q3   = (f >= C_0P75) ? f - C_0P75 : C_0P75 - f;

        pos_class = CLASS_INTEGER_BOUNDARY;
        stability = '0;
        // The danger window is judged on the whole signed word, before the
        // fractional part is considered.
        if (n_s >= DANGER_LO && n_s <= DANGER_HI) begin
            pos_class = CLASS_NEAR_CATASTROPHE;
            stability = C_0P25;
        end else if (f < C_0P125 || f > C_0P875) begin
            pos_class = CLASS_INTEGER_BOUNDARY;
            stability = '0;
        end else if (d_half < C_0P125) begin
            pos_class = CLASS_HALF;
            stability = C_1P0 - (d_half << 2);
        end else if (d_q1 < C_0P125) begin
            pos_class = CLASS_QUARTER;
            stability = C_0P5 - (d_q1 << 1);
        end else if (d_q3 < C_0P125) begin
            pos_class = CLASS_QUARTER;
            stability = C_0P5 - (d_q3 << 1);
        end else if (f == C_0P125 || f == C_0P875) begin
            pos_class = CLASS_INTEGER_BOUNDARY;
            stability = C_0P125;
        end else begin
            // Only f = 0.375 or 0.625 remain: the half/quarter seam.
            pos_class = CLASS_QUARTER;
            stability = C_0P25;
        end
    end

endmodule

// File: rtl/phi_position_scan_scheduler.sv
// Time-multiplexes one classifier lane over NUM_OSCILLATORS exponents, keeps
// per-oscillator class/stability results and persistence counters, and issues
// escape requests round-robin for oscillators that stay unstable.
// Optional build macro: STABILITY_ACCUM_EN adds stability_mean (scan average).
// Ports:
//   clk, rst (async, active-high), clk_en (advance enable)
//   scan_start            in  start pulse, honoured only in IDLE
//   n_packed              in  N*WIDTH signed Q14 exponents
//   busy, scan_done       out status / one-cycle completion pulse
//   position_class_packed out N*2 class results
//   stability_packed      out N*WIDTH stability results
//   esc_pending           out N pending-request flags
//   esc_valid/esc_ready/esc_idx/esc_class  escape request handshake
//
// state    | meaning
// ST_IDLE  | waiting for scan_start
// ST_SCAN  | classifying shadow[idx], one oscillator per enabled cycle
// ST_ISSUE | offering pending escape requests, round-robin
// ST_DONE  | one-cycle scan_done, back to idle
module phi_position_scan_scheduler #(
    parameter  int WIDTH           = 18,
    parameter  int FRAC            = 14,
    parameter  int NUM_OSCILLATORS = 21,
    parameter  int PERSIST_SCANS   = 3,
    localparam int IW              = $clog2(NUM_OSCILLATORS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         scan_start,
    input  logic [NUM_OSCILLATORS*WIDTH-1:0] n_packed,
    output logic                         busy,
    output logic                         scan_done,
    output logic [NUM_OSCILLATORS*2-1:0] position_class_packed,
    output logic [NUM_OSCILLATORS*WIDTH-1:0] stability_packed,
    output logic [NUM_OSCILLATORS-1:0]   esc_pending,
    output logic                         esc_valid,
    input  logic                         esc_ready,
    output logic [IW-1:0]                esc_idx,
    output logic [1:0]                   esc_class
`ifdef STABILITY_ACCUM_EN
    ,
    output logic [WIDTH-1:0]             stability_mean
`endif
);
    import phi_position_pkg::*;

    localparam int N  = NUM_OSCILLATORS;
    localparam int CW = 4;
    localparam logic [CW-1:0] PERSIST = CW'(PERSIST_SCANS);

    scan_state_e state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [N*WIDTH-1:0] shadow_q, shadow_d;
    logic [N*2-1:0]     class_q, class_d;
    logic [N*WIDTH-1:0] stab_q, stab_d;
    logic [N*CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]       pending_q, pending_d;
    logic [N*2-1:0]     esc_cls_q, esc_cls_d;

    logic [1:0]       lane_class;
    logic [WIDTH-1:0] lane_stab;
    logic [CW-1:0]    cnt_cur;
    logic [CW-1:0]    cnt_nxt;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [N-1:0]     sel_onehot;

`ifdef STABILITY_ACCUM_EN
    localparam int ACC_W      = WIDTH + IW;
    localparam int MEAN_SHIFT = 24;
    localparam int PROD_W     = ACC_W + MEAN_SHIFT;
    localparam logic [PROD_W-1:0] MEAN_RECIP =
        PROD_W'(((64'd1 << MEAN_SHIFT) + 64'(N) - 64'd1) / 64'(N));
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mean_q, mean_d;
    logic [PROD_W-1:0] mean_prod;
`endif

    phi_position_classifier_lane #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_lane (
        .n_in      (shadow_q[idx_q*WIDTH +: WIDTH]),
        .pos_class (lane_class),
        .stability (lane_stab)
    );

    always_comb begin
        // Round-robin pick: lowest pending index above rr, else lowest overall
        // (wrap). Descending loops leave the smallest match in sel_idx.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int g = N - 1; g >= 0; g--) begin
            if (pending_q[g] && g <= int'(rr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(g);
            end
        end
        for (int g = N - 1; g >= 0; g--) begin
            if (pending_q[g] && g > int'(rr_q)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(g);
            end
        end
        sel_onehot          = '0;
        sel_onehot[sel_idx] = 1'b1;

        cnt_cur = cnt_q[idx_q*CW +: CW];
        cnt_nxt = (cnt_cur >= PERSIST) ? PERSIST : cnt_cur + CW'(1);

        state_d   = state_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        shadow_d  = shadow_q;
        class_d   = class_q;
        stab_d    = stab_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        esc_cls_d = esc_cls_q;
`ifdef STABILITY_ACCUM_EN
        acc_d     = acc_q;
        mean_d    = mean_q;
        mean_prod = PROD_W'(acc_q) * MEAN_RECIP;
`endif

        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_start) begin
                        shadow_d = n_packed;
                        idx_d    = '0;
                        state_d  = ST_SCAN;
`ifdef STABILITY_ACCUM_EN
                        acc_d    = '0;
`endif
                    end
                end
                ST_SCAN: begin
                    class_d[idx_q*2 +: 2]        = lane_class;
                    stab_d[idx_q*WIDTH +: WIDTH] = lane_stab;
`ifdef STABILITY_ACCUM_EN
                    acc_d = acc_q + ACC_W'(lane_stab);
`endif
                    if (lane_class == CLASS_INTEGER_BOUNDARY ||
                        lane_class == CLASS_NEAR_CATASTROPHE) begin
                        cnt_d[idx_q*CW +: CW] = cnt_nxt;
                        if (cnt_nxt == PERSIST && !pending_q[idx_q]) begin
                            pending_d[idx_q]        = 1'b1;
                            esc_cls_d[idx_q*2 +: 2] = lane_class;
                        end
                    end else begin
                        cnt_d[idx_q*CW +: CW] = '0;
                    end
                    if (idx_q == IW'(N - 1)) begin
                        state_d = (|pending_d) ? ST_ISSUE : ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_ISSUE: begin
                    if (esc_ready && sel_found) begin
                        pending_d[sel_idx]        = 1'b0;
                        cnt_d[sel_idx*CW +: CW]   = '0;
                        rr_d                      = sel_idx;
                        if ((pending_q & ~sel_onehot) == '0) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
`ifdef STABILITY_ACCUM_EN
                    mean_d  = mean_prod[MEAN_SHIFT +: WIDTH];
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rr_q      <= IW'(N - 1);
            shadow_q  <= '0;
            class_q   <= '0;
            stab_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            esc_cls_q <= '0;
`ifdef STABILITY_ACCUM_EN
            acc_q     <= '0;
            mean_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            shadow_q  <= shadow_d;
            class_q   <= class_d;
            stab_q    <= stab_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            esc_cls_q <= esc_cls_d;
`ifdef STABILITY_ACCUM_EN
            acc_q     <= acc_d;
            mean_q    <= mean_d;
`endif
        end
    end

    assign busy                  = (state_q != ST_IDLE);
    assign scan_done             = (state_q == ST_DONE);
    assign esc_valid             = (state_q == ST_ISSUE);
    assign esc_idx               = esc_valid ? sel_idx : '0;
    assign esc_class             = esc_valid ? esc_cls_q[sel_idx*2 +: 2] : 2'b00;
    assign position_class_packed = class_q;
    assign stability_packed      = stab_q;
    assign esc_pending           = pending_q;
`ifdef STABILITY_ACCUM_EN
    assign stability_mean        = mean_q;
`endif

endmodule

// File: tb/tb_phi_position_scan_scheduler.sv
module tb_phi_position_scan_scheduler;
    localparam int N  = 21;
    localparam int W  = 18;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clk_en = 1'b1;
    logic           scan_start = 1'b0;
    logic [N*W-1:0] n_packed = '0;
    logic           busy;
    logic           scan_done;
    logic [N*2-1:0] position_class_packed;
    logic [N*W-1:0] stability_packed;
    logic [N-1:0]   esc_pending;
    logic           esc_valid;
    logic           esc_ready = 1'b0;
    logic [IW-1:0]  esc_idx;
    logic [1:0]     esc_class;

    int n_cmp = 0;
    int n_err = 0;

    int scan_done_cnt, valid_cycles, done_at, n_grants;
    int grants [8];
    int grant_cls [8];

    logic [N*2-1:0] exp_cls;
    logic [N*W-1:0] exp_stab;

    phi_position_scan_scheduler dut (
        .clk                   (clk),
        .rst                   (rst),
        .clk_en                (clk_en),
        .scan_start            (scan_start),
        .n_packed              (n_packed),
        .busy                  (busy),
        .scan_done             (scan_done),
        .position_class_packed (position_class_packed),
        .stability_packed      (stability_packed),
        .esc_pending           (esc_pending),
        .esc_valid             (esc_valid),
        .esc_ready             (esc_ready),
        .esc_idx               (esc_idx),
        .esc_class             (esc_class)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_n(input int g, input int v);
        n_packed[g*W +: W] = W'(v);
    endtask

    task automatic set_all(input int v);
        for (int g = 0; g < N; g++) set_n(g, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_start = 1'b0;
        esc_ready = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full scan; esc_ready is held low for the first ready_delay cycles of
    // esc_valid, then raised. Grants are logged as (idx, class).
    task automatic do_scan(input int ready_delay);
        int  vs;
        bit  fin;
        scan_done_cnt = 0;
        valid_cycles  = 0;
        done_at       = -1;
        n_grants      = 0;
        vs            = 0;
        fin           = 1'b0;
        scan_start = 1'b1;
        esc_ready  = 1'b0;
        @(posedge clk); #1;
        scan_start = 1'b0;
        for (int c = 1; c <= 200 && !fin; c++) begin
            @(posedge clk); #1;
            if (scan_done) begin
                scan_done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (esc_valid) begin
                valid_cycles++;
                if (vs >= ready_delay) begin
                    esc_ready = 1'b1;
                    if (n_grants < 8) begin
                        grants[n_grants]    = int'(esc_idx);
                        grant_cls[n_grants] = int'(esc_class);
                    end
                    n_grants++;
                end else begin
                    esc_ready = 1'b0;
                end
                vs++;
            end else begin
                esc_ready = 1'b0;
            end
            if (!busy) fin = 1'b1;
        end
        esc_ready = 1'b0;
        check_val("scan_terminates", 512'(fin), 512'(1));
    endtask

    initial begin
        int  tbl_n   [15];
        int  tbl_cls [15];
        int  tbl_stb [15];
        int  edges;
        bit  seen;

        // Reset state
        #1;
        check_val("rst_busy", 512'(busy), 512'(0));
        check_val("rst_scan_done", 512'(scan_done), 512'(0));
        check_val("rst_esc_valid", 512'(esc_valid), 512'(0));
        check_val("rst_class", 512'(position_class_packed), 512'(0));
        check_val("rst_stab", 512'(stability_packed), 512'(0));
        check_val("rst_pending", 512'(esc_pending), 512'(0));
        check_val("rst_esc_idx", 512'(esc_idx), 512'(0));
        do_reset();

        // All oscillators at 0.5
        set_all(8192);
        do_scan(0);
        for (int g = 0; g < N; g++) begin
            exp_cls[g*2 +: 2]  = 2'b01;
            exp_stab[g*W +: W] = W'(16384);
        end
        check_val("half_class", 512'(position_class_packed), 512'(exp_cls));
        check_val("half_stab", 512'(stability_packed), 512'(exp_stab));
        check_val("half_done_cnt", 512'(scan_done_cnt), 512'(1));
        check_val("half_latency", 512'(done_at), 512'(N));
        check_val("half_no_valid", 512'(valid_cycles), 512'(0));

        // Danger oscillator 3 for three scans
        do_reset();
        set_all(8192);
        set_n(3, 23000);
        do_scan(0);
        do_scan(0);
        check_val("danger_no_pend_s2", 512'(esc_pending), 512'(0));
        check_val("danger_no_valid_s2", 512'(valid_cycles), 512'(0));
        do_scan(2);
        check_val("danger_grants", 512'(n_grants), 512'(1));
        check_val("danger_idx", 512'(grants[0]), 512'(3));
        check_val("danger_class", 512'(grant_cls[0]), 512'(3));
        check_val("danger_stab3", 512'(stability_packed[3*W +: W]), 512'(4096));
        check_val("danger_pend_clr", 512'(esc_pending), 512'(0));

        // Two integer-boundary oscillators, round-robin order and pointer
        do_reset();
        set_all(8192);
        set_n(2, 0);
        set_n(7, 0);
        do_scan(0);
        do_scan(0);
        do_scan(5);
        check_val("rr_grants", 512'(n_grants), 512'(2));
        check_val("rr_first", 512'(grants[0]), 512'(2));
        check_val("rr_second", 512'(grants[1]), 512'(7));
        check_val("rr_class", 512'(grant_cls[0]), 512'(0));
        check_val("rr_valid_cycles", 512'(valid_cycles), 512'(7));
        check_val("rr_done_cnt", 512'(scan_done_cnt), 512'(1));
        do_scan(0);
        do_scan(0);
        check_val("rr_no_valid_s5", 512'(valid_cycles), 512'(0));
        do_scan(0);
        check_val("rr2_first", 512'(grants[0]), 512'(2));
        check_val("rr2_second", 512'(grants[1]), 512'(7));

        // Lane edge values
        do_reset();
        set_all(8192);
        tbl_n   = '{2047, 2048, 6144, 10239, 22118, 25396, -8192, 14337,
                    4096, 12388, 25395, 6145, 22117, 14336, 10240};
        tbl_cls = '{0, 0, 2, 1, 3, 1, 1, 0, 2, 2, 3, 1, 2, 0, 2};
        tbl_stb = '{0, 2048, 4096, 8196, 4096, 13104, 16384, 0,
                    8192, 7992, 4096, 8196, 4918, 2048, 4096};
        for (int g = 0; g < 15; g++) set_n(g, tbl_n[g]);
        do_scan(0);
        for (int g = 0; g < 15; g++) begin
            check_val($sformatf("lane_cls_%0d", g),
                      512'(position_class_packed[g*2 +: 2]), 512'(tbl_cls[g]));
            check_val($sformatf("lane_stab_%0d", g),
                      512'(stability_packed[g*W +: W]), 512'(tbl_stb[g]));
        end
        check_val("lane_cls_20", 512'(position_class_packed[20*2 +: 2]), 512'(1));

        // Persistence interrupted by a stable scan
        do_reset();
        set_all(8192);
        set_n(5, 0);
        do_scan(0);
        do_scan(0);
        set_n(5, 8192);
        do_scan(0);
        set_n(5, 0);
        do_scan(0);
        do_scan(0);
        check_val("persist_no_pend", 512'(esc_pending), 512'(0));
        check_val("persist_no_valid", 512'(valid_cycles), 512'(0));
        do_scan(0);
        check_val("persist_third_grants", 512'(n_grants), 512'(1));
        check_val("persist_third_idx", 512'(grants[0]), 512'(5));

        // scan_start during SCAN ignored; n_packed snapshot
        do_reset();
        set_all(8192);
        scan_done_cnt = 0;
        done_at = -1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_all(0);
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        edges = 5;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            edges++;
            if (scan_done) begin
                scan_done_cnt++;
                if (done_at < 0) done_at = edges;
            end
            if (!busy) seen = 1'b1;
        end
        check_val("restart_ignored_latency", 512'(done_at), 512'(N));
        check_val("restart_done_cnt", 512'(scan_done_cnt), 512'(1));
        check_val("snapshot_class", 512'(position_class_packed), 512'(exp_cls));
        repeat (3) @(posedge clk);
        #1;
        check_val("start_not_queued", 512'(busy), 512'(0));

        // clk_en gates the handshake; rst mid-ISSUE clears everything
        do_reset();
        set_all(8192);
        set_n(3, 0);
        do_scan(0);
        do_scan(0);
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk); #1;
            if (esc_valid) seen = 1'b1;
        end
        check_val("issue_reached", 512'(seen), 512'(1));
        clk_en = 1'b0;
        esc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("clken_hold_valid", 512'(esc_valid), 512'(1));
        check_val("clken_hold_pend", 512'(esc_pending), 512'(1 << 3));
        check_val("clken_hold_idx", 512'(esc_idx), 512'(3));
        rst = 1'b1;
        #1;
        check_val("midrst_valid", 512'(esc_valid), 512'(0));
        check_val("midrst_busy", 512'(busy), 512'(0));
        check_val("midrst_class", 512'(position_class_packed), 512'(0));
        check_val("midrst_stab", 512'(stability_packed), 512'(0));
        check_val("midrst_pend", 512'(esc_pending), 512'(0));
        esc_ready = 1'b0;
        clk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
